// File: rtl/lfsr_prbs_test_ctrl_pkg.sv
// Shared constants for the PRBS link-test sequencer: FSM encodings and
// the guard width used by the saturating error counters.
package lfsr_prbs_test_ctrl_pkg;

  localparam int unsigned STATE_WIDTH = 3;

  localparam logic [STATE_WIDTH-1:0] ST_IDLE  = 3'd0;
  localparam logic [STATE_WIDTH-1:0] ST_RESET = 3'd1;
  localparam logic [STATE_WIDTH-1:0] ST_RUN   = 3'd2;
  localparam logic [STATE_WIDTH-1:0] ST_DRAIN = 3'd3;
  localparam logic [STATE_WIDTH-1:0] ST_DONE  = 3'd4;

  // One carry bit above the counter width flags an overflow to clamp.
  localparam int unsigned SAT_GUARD_BITS = 1;

endpackage

// File: rtl/lfsr_prbs_test_ctrl_if.sv
// Control/status link between the test sequencer and the PRBS
// generator/checker pair.
interface lfsr_prbs_test_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 64
);
  logic                  gen_rst;
  logic                  gen_enable;
  logic                  chk_rst;
  logic [DATA_WIDTH-1:0] chk_err;
  logic                  chk_err_valid;

  modport master (
    output gen_rst, gen_enable, chk_rst,
    input  chk_err, chk_err_valid
  );

  modport slave (
    input  gen_rst, gen_enable, chk_rst,
    output chk_err, chk_err_valid
  );
endinterface

// File: rtl/lfsr_prbs_popcount.sv
// Combinational population count of the checker error vector.
module lfsr_prbs_popcount #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [DATA_WIDTH-1:0]       data,
  output logic [$clog2(DATA_WIDTH):0] count_c
);
  localparam int unsigned COUNT_WIDTH = $clog2(DATA_WIDTH) + 1;

  logic [COUNT_WIDTH-1:0] acc;

  always_comb begin
    acc = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      acc = acc + COUNT_WIDTH'(data[i]);
    end
    count_c = acc;
  end
endmodule

// File: rtl/lfsr_prbs_test_ctrl.sv
// PRBS link-test sequencer: resets gen/chk, streams run_len words, skips
// sync words, accumulates saturating error counts and reports the verdict.
module lfsr_prbs_test_ctrl
  import lfsr_prbs_test_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned LEN_WIDTH     = 32,
  parameter int unsigned CNT_WIDTH     = 32,
  parameter int unsigned RST_CYCLES    = 4,
  parameter int unsigned SYNC_WORDS    = 2,
  parameter int unsigned DRAIN_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [LEN_WIDTH-1:0]  run_len,
  lfsr_prbs_test_ctrl_if.master prbs,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  timeout,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  words_checked,
  output logic [CNT_WIDTH-1:0]  word_err_cnt,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt
);
  localparam int unsigned POP_WIDTH      = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned RST_CNT_WIDTH  = $clog2(RST_CYCLES + 1);
  localparam int unsigned IDLE_CNT_WIDTH = $clog2(DRAIN_TIMEOUT + 1);
  localparam int unsigned SUM_WIDTH      = CNT_WIDTH + SAT_GUARD_BITS;

  logic [STATE_WIDTH-1:0]    state, state_next;
  logic [LEN_WIDTH-1:0]      len_q, len_next;
  logic [LEN_WIDTH-1:0]      sent_q, sent_next;
  logic [LEN_WIDTH-1:0]      rcv_q, rcv_next;
  logic [RST_CNT_WIDTH-1:0]  rst_cnt_q, rst_cnt_next;
  logic [IDLE_CNT_WIDTH-1:0] idle_q, idle_next;
  logic [LEN_WIDTH-1:0]      words_next;
  logic [CNT_WIDTH-1:0]      werr_next, berr_next;
  logic                      timeout_next, aborted_next;
  logic                      acc;
  logic [POP_WIDTH-1:0]      pop_c;

  lfsr_prbs_popcount #(.DATA_WIDTH(DATA_WIDTH)) u_popcount (
    .data    (prbs.chk_err),
    .count_c (pop_c)
  );

  // Add with clamp at all-ones; the guard bit catches the carry-out.
  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [POP_WIDTH-1:0] b);
    logic [SUM_WIDTH-1:0] sum;
    sum = SUM_WIDTH'(a) + SUM_WIDTH'(b);
    return sum[SUM_WIDTH-1] ? '1 : sum[CNT_WIDTH-1:0];
  endfunction

  always_comb begin
    state_next   = state;
    len_next     = len_q;
    sent_next    = sent_q;
    rcv_next     = rcv_q;
    rst_cnt_next = rst_cnt_q;
    idle_next    = idle_q;
    words_next   = words_checked;
    werr_next    = word_err_cnt;
    berr_next    = bit_err_cnt;
    timeout_next = timeout;
    aborted_next = aborted;

    // Received-word accounting; an abort cycle freezes the counters.
    acc = prbs.chk_err_valid && !abort && ((state == ST_RUN) || (state == ST_DRAIN));
    if (acc) begin
      rcv_next = rcv_q + LEN_WIDTH'(1);
      if (rcv_q >= LEN_WIDTH'(SYNC_WORDS)) begin
        words_next = words_checked + LEN_WIDTH'(1);
        werr_next  = sat_add(word_err_cnt, POP_WIDTH'(pop_c != '0));
        berr_next  = sat_add(bit_err_cnt, pop_c);
      end
    end

    case (state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_next   = ST_RESET;
          len_next     = run_len;
          sent_next    = '0;
          rcv_next     = '0;
          rst_cnt_next = RST_CNT_WIDTH'(RST_CYCLES);
          idle_next    = '0;
          words_next   = '0;
          werr_next    = '0;
          berr_next    = '0;
          timeout_next = 1'b0;
          aborted_next = 1'b0;
        end
      end
      ST_RESET: begin
        if (abort) begin
          state_next   = ST_DONE;
          aborted_next = 1'b1;
        end else if (rst_cnt_q == RST_CNT_WIDTH'(1)) begin
          state_next = (len_q == '0) ? ST_DONE : ST_RUN;
        end else begin
          rst_cnt_next = rst_cnt_q - RST_CNT_WIDTH'(1);
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_next   = ST_DONE;
          aborted_next = 1'b1;
        end else begin
          sent_next = sent_q + LEN_WIDTH'(1);
          if (sent_next == len_q) begin
            state_next = ST_DRAIN;
            idle_next  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_next   = ST_DONE;
          aborted_next = 1'b1;
        end else if (rcv_next >= len_q) begin
          state_next = ST_DONE;
        end else if (prbs.chk_err_valid) begin
          idle_next = '0;
        end else if (idle_q == IDLE_CNT_WIDTH'(DRAIN_TIMEOUT - 1)) begin
          state_next   = ST_DONE;
          timeout_next = 1'b1;
        end else begin
          idle_next = idle_q + IDLE_CNT_WIDTH'(1);
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs decode the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      len_q           <= '0;
      sent_q          <= '0;
      rcv_q           <= '0;
      rst_cnt_q       <= '0;
      idle_q          <= '0;
      words_checked   <= '0;
      word_err_cnt    <= '0;
      bit_err_cnt     <= '0;
      timeout         <= 1'b0;
      aborted         <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      prbs.gen_rst    <= 1'b1;
      prbs.chk_rst    <= 1'b1;
      prbs.gen_enable <= 1'b0;
    end else begin
      state           <= state_next;
      len_q           <= len_next;
      sent_q          <= sent_next;
      rcv_q           <= rcv_next;
      rst_cnt_q       <= rst_cnt_next;
      idle_q          <= idle_next;
      words_checked   <= words_next;
      word_err_cnt    <= werr_next;
      bit_err_cnt     <= berr_next;
      timeout         <= timeout_next;
      aborted         <= aborted_next;
      busy            <= state_next inside {ST_RESET, ST_RUN, ST_DRAIN};
      done            <= (state_next == ST_DONE);
      pass            <= (state_next == ST_DONE) && (berr_next == '0) &&
                         !timeout_next && !aborted_next;
      prbs.gen_rst    <= (state_next == ST_RESET);
      prbs.chk_rst    <= (state_next == ST_RESET);
      prbs.gen_enable <= (state_next == ST_RUN);
    end
  end
endmodule

// File: tb/tb_lfsr_prbs_test_ctrl.sv
// Bench for lfsr_prbs_test_ctrl: 3-cycle loopback model with error
// injection, expected run results queued at launch and compared at done.
module tb_lfsr_prbs_test_ctrl;
  localparam int unsigned DW   = 64;
  localparam int unsigned LW   = 32;
  localparam int unsigned CW   = 12;
  localparam int unsigned RSTC = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TMO  = 256;

  logic          clk = 1'b0;
  logic          rst, start, abort;
  logic [LW-1:0] run_len;
  logic          busy, done, pass, timeout, aborted;
  logic [LW-1:0] words_checked;
  logic [CW-1:0] word_err_cnt, bit_err_cnt;

  lfsr_prbs_test_ctrl_if #(.DATA_WIDTH(DW)) prbs_if ();

  lfsr_prbs_test_ctrl #(
    .DATA_WIDTH(DW), .LEN_WIDTH(LW), .CNT_WIDTH(CW),
    .RST_CYCLES(RSTC), .SYNC_WORDS(SYNC), .DRAIN_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .run_len(run_len),
    .prbs(prbs_if),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout), .aborted(aborted),
    .words_checked(words_checked), .word_err_cnt(word_err_cnt), .bit_err_cnt(bit_err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string tag;
    int    words, werr, berr;
    bit    pass_e, tmo, abt;
    int    en, rsts, drain;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  // Cycle counters for gen_enable, gen_rst and drain occupancy.
  int en_cyc = 0, grst_cyc = 0, drain_cyc = 0;
  always @(negedge clk) begin
    if (prbs_if.gen_enable === 1'b1) en_cyc++;
    if (prbs_if.gen_rst === 1'b1) grst_cyc++;
    if (busy === 1'b1 && prbs_if.gen_enable === 1'b0 && prbs_if.gen_rst === 1'b0) drain_cyc++;
  end

  // Loopback model: each enabled generator word returns 3 cycles later.
  bit            loop_on  = 1'b1;
  bit            all_ones = 1'b0;
  int            rx_idx   = 0;
  logic [DW-1:0] err_map [int];
  initial begin
    logic [3:0] pipe;
    pipe = '0;
    prbs_if.chk_err_valid = 1'b0;
    prbs_if.chk_err       = '0;
    forever begin
      @(posedge clk);
      #1;
      pipe = {pipe[2:0], (prbs_if.gen_enable === 1'b1) && loop_on};
      if (pipe[3]) begin
        prbs_if.chk_err_valid = 1'b1;
        if (all_ones) prbs_if.chk_err = '1;
        else if (err_map.exists(rx_idx)) prbs_if.chk_err = err_map[rx_idx];
        else prbs_if.chk_err = '0;
        rx_idx++;
      end else begin
        prbs_if.chk_err_valid = 1'b0;
        prbs_if.chk_err       = '0;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic exp_t mk(input string tag, input int words, input int werr,
                              input int berr, input bit pass_e, input bit tmo,
                              input bit abt, input int en, input int rsts, input int drain);
    exp_t e;
    e.tag = tag; e.words = words; e.werr = werr; e.berr = berr;
    e.pass_e = pass_e; e.tmo = tmo; e.abt = abt;
    e.en = en; e.rsts = rsts; e.drain = drain;
    return e;
  endfunction

  int base_en, base_rst, base_drain, base_rx;

  task automatic launch(input logic [LW-1:0] len, input bit with_abort);
    base_en = en_cyc; base_rst = grst_cyc; base_drain = drain_cyc; base_rx = rx_idx;
    run_len = len;
    start   = 1'b1;
    abort   = with_abort;
    tick(1);
    start   = 1'b0;
    abort   = 1'b0;
    run_len = '0;
  endtask

  task automatic finish_run();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    e = sb.pop_front();
    check({e.tag, "_done"}, 64'(seen), 64'd1);
    check({e.tag, "_words"}, 64'(words_checked), 64'(e.words));
    check({e.tag, "_werr"}, 64'(word_err_cnt), 64'(e.werr));
    check({e.tag, "_berr"}, 64'(bit_err_cnt), 64'(e.berr));
    check({e.tag, "_pass"}, 64'(pass), 64'(e.pass_e));
    check({e.tag, "_timeout"}, 64'(timeout), 64'(e.tmo));
    check({e.tag, "_aborted"}, 64'(aborted), 64'(e.abt));
    check({e.tag, "_busy"}, 64'(busy), 64'd0);
    check({e.tag, "_en_cycles"}, 64'(en_cyc - base_en), 64'(e.en));
    check({e.tag, "_rst_cycles"}, 64'(grst_cyc - base_rst), 64'(e.rsts));
    check({e.tag, "_drain_cycles"}, 64'(drain_cyc - base_drain), 64'(e.drain));
    tick(8);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; run_len = '0;
    tick(3);
    check("rst_gen_rst", 64'(prbs_if.gen_rst), 64'd1);
    check("rst_chk_rst", 64'(prbs_if.chk_rst), 64'd1);
    check("rst_gen_enable", 64'(prbs_if.gen_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_pass", 64'(pass), 64'd0);
    check("rst_words", 64'(words_checked), 64'd0);
    check("rst_berr", 64'(bit_err_cnt), 64'd0);
    rst = 1'b0;
    tick(1);
    check("rel_gen_rst", 64'(prbs_if.gen_rst), 64'd0);
    check("rel_chk_rst", 64'(prbs_if.chk_rst), 64'd0);
    tick(2);

    // Clean loopback; a start pulse mid-run must be ignored.
    sb.push_back(mk("clean", 98, 0, 0, 1'b1, 1'b0, 1'b0, 100, RSTC, 3));
    launch(100, 1'b0);
    tick(30);
    run_len = 5; start = 1'b1;
    tick(1);
    start = 1'b0; run_len = '0;
    finish_run();

    // Abort while DONE is ignored.
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    tick(1);
    check("done_abort_aborted", 64'(aborted), 64'd0);
    check("done_abort_pass", 64'(pass), 64'd1);
    check("done_abort_done", 64'(done), 64'd1);

    // Error injection on post-sync words 5 and 9.
    sb.push_back(mk("errs", 98, 2, $countones(64'h3) + $countones(64'h1),
                    1'b0, 1'b0, 1'b0, 100, RSTC, 3));
    launch(100, 1'b0);
    err_map[base_rx + SYNC + 4] = 64'h3;
    err_map[base_rx + SYNC + 8] = 64'h1;
    finish_run();

    // Broken loopback: drain times out.
    loop_on = 1'b0;
    sb.push_back(mk("tmo", 0, 0, 0, 1'b0, 1'b1, 1'b0, 10, RSTC, TMO));
    launch(10, 1'b0);
    finish_run();
    loop_on = 1'b1;

    // Abort in RUN cycle 20 of a long run.
    begin
      bit seen_en;
      seen_en = 1'b0;
      launch(1000, 1'b0);
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (prbs_if.gen_enable === 1'b1) begin
          seen_en = 1'b1;
          break;
        end
      end
      check("abort_run_entry", 64'(seen_en), 64'd1);
      tick(19);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      check("abort_gen_enable", 64'(prbs_if.gen_enable), 64'd0);
      check("abort_gen_rst", 64'(prbs_if.gen_rst), 64'd0);
      check("abort_done", 64'(done), 64'd1);
      check("abort_aborted", 64'(aborted), 64'd1);
      check("abort_pass", 64'(pass), 64'd0);
      check("abort_en_cycles", 64'(en_cyc - base_en), 64'd20);
      tick(3);
      abort = 1'b1;
      tick(1);
      abort = 1'b0;
      tick(1);
      check("abort2_aborted", 64'(aborted), 64'd1);
      check("abort2_done", 64'(done), 64'd1);
      check("abort2_busy", 64'(busy), 64'd0);
      tick(8);
    end

    // Zero-length run goes straight from RESET to DONE.
    sb.push_back(mk("zero", 0, 0, 0, 1'b1, 1'b0, 1'b0, 0, RSTC, 0));
    launch(0, 1'b0);
    finish_run();

    // Two words are both sync words; start beats a simultaneous abort.
    sb.push_back(mk("two", 0, 0, 0, 1'b1, 1'b0, 1'b0, 2, RSTC, 3));
    launch(2, 1'b1);
    finish_run();

    // All-ones errors saturate the bit counter.
    all_ones = 1'b1;
    sb.push_back(mk("sat", 78, 78, (78 * 64 > 4095) ? 4095 : 78 * 64,
                    1'b0, 1'b0, 1'b0, 80, RSTC, 3));
    launch(80, 1'b0);
    finish_run();
    all_ones = 1'b0;

    // Reset in the middle of RUN.
    launch(100, 1'b0);
    tick(15);
    rst = 1'b1;
    tick(1);
    check("midrst_gen_rst", 64'(prbs_if.gen_rst), 64'd1);
    check("midrst_chk_rst", 64'(prbs_if.chk_rst), 64'd1);
    check("midrst_gen_enable", 64'(prbs_if.gen_enable), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_words", 64'(words_checked), 64'd0);
    check("midrst_werr", 64'(word_err_cnt), 64'd0);
    tick(1);
    rst = 1'b0;
    tick(1);
    check("midrst_rel_gen_rst", 64'(prbs_if.gen_rst), 64'd0);
    check("midrst_rel_done", 64'(done), 64'd0);
    tick(10);

    sb.push_back(mk("after_rst", 18, 0, 0, 1'b1, 1'b0, 1'b0, 20, RSTC, 3));
    launch(20, 1'b0);
    finish_run();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/lfsr_prbs_test_ctrl.md
# lfsr_prbs_test_ctrl

Sequencer for a PRBS link test built from one `lfsr_prbs_gen` and one `lfsr_prbs_chk`. It resets both blocks, streams a programmed number of generator words, discards the checker's synchronisation words and accumulates bit and word error counts. It then drains the loopback path and reports pass, fail, timeout or abort. It sits between a register/CSR front end and the PRBS generator/checker pair of a BERT or link-bring-up harness.

## Interface
- `DATA_WIDTH`, 64: width of the checker error vector (matches the generator/checker `OUTPUT_WIDTH`/`DATA_WIDTH`).
- `LEN_WIDTH`, 32: width of the run-length and word counters.
- `CNT_WIDTH`, 32: width of the saturating error counters.
- `RST_CYCLES`, 4: cycles for which gen/chk reset is held at test start (≥1).
- `SYNC_WORDS`, 2: number of initial checker valid words excluded from error counting.
- `DRAIN_TIMEOUT`, 256: idle cycles without `chk_err_valid` after which drain aborts with timeout.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle pulse; begins a test.
- `abort` in 1: single-cycle pulse; ends the test early.
- `run_len` in LEN_WIDTH: number of generator words; sampled on accepted `start`.
- `gen_rst` out 1: reset to generator.
- `gen_enable` out 1: generator advance enable.
- `chk_rst` out 1: reset to checker.
- `chk_err` in DATA_WIDTH: checker error bits (1 = bit mismatch).
- `chk_err_valid` in 1: `chk_err` is valid this cycle.
- `busy` out 1: state ≠ IDLE/DONE.
- `done` out 1: state = DONE.
- `pass` out 1: done, no errors, no timeout, no abort.
- `timeout` out 1: sticky; drain timed out.
- `aborted` out 1: sticky; test ended by `abort`.
- `words_checked` out LEN_WIDTH: post-sync valid words received.
- `word_err_cnt` out CNT_WIDTH: post-sync words with ≥1 error bit.
- `bit_err_cnt` out CNT_WIDTH: post-sync total error bits.

## Operation
- States: IDLE, RESET, RUN, DRAIN, DONE.
- IDLE/DONE + `start` → RESET. Clears all counters and the sticky flags, latches `run_len`, loads the reset counter with RST_CYCLES. `start` in any other state is ignored.
- RESET: `gen_rst`=`chk_rst`=1 for exactly RST_CYCLES cycles, then → RUN. If the latched length is 0, go → DONE instead.
- RUN: `gen_enable`=1 every cycle. The sent counter increments each cycle. After the cycle in which sent reaches the latched length → DRAIN.
- DRAIN: `gen_enable`=0. Go → DONE when total valid words received (including sync words) = latched length. Go → DONE with `timeout`=1 when DRAIN_TIMEOUT consecutive cycles pass with no `chk_err_valid`.
- Received-word accounting runs in RUN and DRAIN:
  - The first SYNC_WORDS valids only increment the received count.
  - Later valids increment `words_checked`.
  - `bit_err_cnt` += popcount(`chk_err`).
  - `word_err_cnt` += (`chk_err`≠0).
  - Both error counters saturate at all-ones. Adding past the maximum clamps and never wraps.
- Valids in IDLE, RESET or DONE are ignored.
- `abort` in RESET, RUN or DRAIN → DONE next cycle with `aborted`=1. `gen_enable` and both resets deassert. Counters freeze.
- Simultaneous `abort`+`start` in IDLE/DONE: `start` wins. `abort` is ignored outside the active states.
- `pass` = DONE ∧ `bit_err_cnt`=0 ∧ ¬`timeout` ∧ ¬`aborted`.

## Timing
- Reset values: state IDLE. All outputs 0 except `gen_rst`=`chk_rst`=1 while `rst` is high; these fall to 0 the cycle after `rst` deasserts.
- All outputs are registered. `start` at cycle 0 → `gen_rst` high in cycles 1..RST_CYCLES → `gen_enable` high in cycles RST_CYCLES+1 .. RST_CYCLES+run_len.
- Counter updates are visible one cycle after the qualifying `chk_err_valid`. `done` rises in the cycle after the terminating valid, timeout or abort.
- The popcount may be pipelined by one stage. DONE entry must then wait for the stage to empty, so final counts are complete when `done` rises.
- `rst` mid-test: immediate return to IDLE, counters cleared.

## Structure
- A shared package/header holds the state encodings and the counter-saturation helper constant.
- One sub-module, `lfsr_prbs_popcount` (DATA_WIDTH in, $clog2(DATA_WIDTH)+1 out, optional output register).

## Test plan
- Loopback, no errors, run_len=100, SYNC_WORDS=2 → `done`, `pass`=1, `words_checked`=98, both error counters 0; `gen_enable` high exactly 100 cycles.
- Inject `chk_err`=64'h3 on post-sync word 5 and 64'h1 on word 9 → `bit_err_cnt`=3, `word_err_cnt`=2, `pass`=0.
- Break loopback (no valids) with run_len=10 → DRAIN lasts 256 cycles, then `timeout`=1, `pass`=0, `words_checked`=0.
- `abort` at RUN cycle 20 of run_len=1000 → `gen_enable` low next cycle, `done`=1, `aborted`=1; a second `abort` has no effect.
- run_len=0 → RESET lasts 4 cycles, then DONE with `pass`=1 and all counters 0; run_len=2 gives `words_checked`=0.
- Force `chk_err`=all-ones for 2^26 words with CNT_WIDTH=32 → `bit_err_cnt` holds at 32'hFFFFFFFF without wrapping. `rst` mid-RUN → IDLE, counters 0, `gen_rst` asserted during reset.
